// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// result_o = {remainder, quotient}; ready_o releases the divide stall.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  input  logic                 hold_i,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  divState_t        state;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             qNeg;
  logic             rNeg;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] quoFinal;
  logic [WIDTH-1:0] remFinal;

  // Operand magnitudes and one restoring step; quo doubles as the dividend shifter.
  always_comb begin
    mag1     = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2     = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    trial    = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    nextRem  = {rem[WIDTH-2:0], quo[WIDTH-1]};
    nextQuo  = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      nextRem = trial[WIDTH-1:0];
      nextQuo = {quo[WIDTH-2:0], 1'b1};
    end
    quoFinal = qNeg ? -nextQuo : nextQuo;
    remFinal = rNeg ? -nextRem : nextRem;
  end

  // Control FSM with registered ready/result; annul overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      qNeg     <= 1'b0;
      rNeg     <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else if (annul_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            divisor <= mag2;
            quo     <= mag1;
            rem     <= '0;
            cnt     <= '0;
            qNeg    <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rNeg    <= signed_i & opdata1_i[WIDTH-1];
            if (opdata2_i == '0) begin
              state    <= DONE;
              ready_o  <= 1'b1;
              result_o <= '0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= nextRem;
          quo <= nextQuo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state    <= DONE;
            ready_o  <= 1'b1;
            result_o <= {remFinal, quoFinal};
          end
        end
        DONE: begin
          if (!hold_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        hold_i;
  logic        ready_o;
  logic [63:0] result_o;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .hold_i(hold_i), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Reference quotient/remainder from plain 64-bit arithmetic (remainder takes dividend sign).
  function automatic logic [63:0] expRes(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model: idle / counting down the 32-cycle iteration / result presented.
  int          mPhase;
  int          mLeft;
  logic        mReady;
  logic [63:0] mRes;
  logic [63:0] mPending;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mPhase <= 0; mLeft <= 0; mReady <= 1'b0; mRes <= 64'd0; mPending <= 64'd0;
    end else if (annul_i) begin
      mPhase <= 0; mReady <= 1'b0;
    end else if (mPhase == 0) begin
      if (start_i) begin
        if (opdata2_i == 32'd0) begin
          mPhase <= 2; mReady <= 1'b1; mRes <= 64'd0;
        end else begin
          mPhase <= 1; mLeft <= 32; mPending <= expRes(opdata1_i, opdata2_i, signed_i);
        end
      end
    end else if (mPhase == 1) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin
        mPhase <= 2; mReady <= 1'b1; mRes <= mPending;
      end
    end else if (!hold_i) begin
      mPhase <= 0; mReady <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    tests++;
    if (ready_o !== mReady) begin
      fails++;
      $display("FAIL model_ready t=%0t got=%b want=%b", $time, ready_o, mReady);
    end
    if (mReady || !resetn) begin
      tests++;
      if (result_o !== mRes) begin
        fails++;
        $display("FAIL model_result t=%0t got=%h want=%h", $time, result_o, mRes);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called just after the capture edge: counts edges until ready and checks result.
  task automatic waitResult(input string name, input logic [63:0] want, input int lat);
    int n;
    n = 1;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_result"}, result_o, want);
  endtask

  // Start a divide from IDLE, then scramble the operand inputs while it runs.
  task automatic runDiv(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] want, input int lat);
    opdata1_i = a; opdata2_i = b; signed_i = s; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~s;
    waitResult(name, want, lat);
  endtask

  task automatic finishDone(input string name);
    tick();
    check({name, "_ready_drop"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; opdata1_i = 32'd0;
    opdata2_i = 32'd0; annul_i = 1'b0; hold_i = 1'b0;
    tick(); tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("model_pin_100_7", expRes(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    check("model_pin_min_m1", expRes(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
    resetn = 1'b1;
    tick();

    runDiv("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
    finishDone("u100_7");
    runDiv("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
    finishDone("s_m7_2");
    runDiv("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
    finishDone("s_7_m2");
    runDiv("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33);
    finishDone("s_min_m1");
    runDiv("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33);
    finishDone("u_max_1");
    runDiv("u_max_16", 32'hFFFFFFFF, 32'd16, 1'b0, 64'h0000000F_0FFFFFFF, 33);
    finishDone("u_max_16");
    runDiv("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33);
    finishDone("s_m100_m7");
    runDiv("u_div0", 32'd12345, 32'd0, 1'b0, 64'd0, 1);
    finishDone("u_div0");
    runDiv("s_div0", 32'hFFFFFFFB, 32'd0, 1'b1, 64'd0, 1);
    finishDone("s_div0");

    // Annul mid-iteration, with a divide-by-zero start in the same cycle that must be ignored.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    annul_i = 1'b1; start_i = 1'b1; opdata2_i = 32'd0;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    runDiv("after_annul", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);

    // Hold keeps DONE for 4 cycles; a held start then captures in the next IDLE cycle.
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, 64'h00000002_0000000E);
    end
    hold_i = 1'b0; start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_i = 1'b1;
    tick();
    check("hold_release", 64'(ready_o), 64'd0);
    tick();
    start_i = 1'b0;
    waitResult("b2b_1000_3", 64'h00000001_0000014D, 33);
    finishDone("b2b_1000_3");

    // Asynchronous reset in the middle of an operation.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    #1;
    check("async_rst_ready", 64'(ready_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    runDiv("after_reset", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
    finishDone("after_reset");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
